calc_alu_seq: RTL

- Multi-cycle arithmetic sequencer for the keypad calculator.
- Takes two 2-digit BCD operands and an operator code from the key-entry state machine on a start pulse.
- Converts the operands to binary and runs add, subtract, iterative shift-add multiply or restoring divide.
- Converts the result back to 4 BCD digits with sign and error flags for the 7-segment formatting logic, then signals completion with a one-cycle done pulse.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 68 ++++++
 rtl/calc_alu_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants and helpers for the keypad calculator datapath:
// operator codes, one-hot sequencer states and BCD operand conversion.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'ha;
  localparam logic [3:0] OP_SUB = 4'hb;
  localparam logic [3:0] OP_MUL = 4'hc;
  localparam logic [3:0] OP_DIV = 4'hd;
  localparam logic [3:0] OP_EQ  = 4'he;
  localparam logic [3:0] OP_CLR = 4'hf;

  // Digit code the display formatter uses for an unlit position
  localparam logic [4:0] BLANK = 5'd16;

  localparam int OPND_BIN_W = 7;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_LOAD = 5'b00010,
    ST_EXEC = 5'b00100,
    ST_CONV = 5'b01000,
    ST_DONE = 5'b10000
  } state_t;

  // tens*10 + ones as (t<<3)+(t<<1)+o; wraps for non-BCD digits, which are flagged separately
  function automatic logic [OPND_BIN_W-1:0] bcd2bin(input logic [3:0] t, input logic [3:0] o);
    return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, o};
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per clock, BIN_W shifts total.
// The first shift is folded into the load since a cleared BCD field needs no correction.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (clr) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (load) begin
      shift_reg <= bin << 1;
      bcd_reg   <= BCD_W'(bin[BIN_W-1]);
      cnt_reg   <= CNT_W'(BIN_W - 1);
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else if (busy_reg) begin
      {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
      cnt_reg  <= cnt_reg - 1'b1;
      busy_reg <= (cnt_reg != CNT_W'(1));
      done_reg <= (cnt_reg == CNT_W'(1));
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule

// File: rtl/calc_alu_seq.sv
// Multi-cycle calculator ALU: BCD operands in, add/sub/shift-add mul/restoring div,
// double-dabble back to 4 BCD digits with sign and error flags, one-cycle done pulse.
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int OPND_W   = 7,
  parameter int RES_W    = 14,
  parameter int CONV_CYC = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] op,
  input  logic [3:0] a_tens,
  input  logic [3:0] a_ones,
  input  logic [3:0] b_tens,
  input  logic [3:0] b_ones,
  output logic       busy,
  output logic       done,
  output logic [3:0] res_d3,
  output logic [3:0] res_d2,
  output logic [3:0] res_d1,
  output logic [3:0] res_d0,
  output logic       res_neg,
  output logic       err
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MULDIV_LAST = CNT_W'(OPND_W - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYC - 1);

  state_t state_reg, state_next;

  logic [3:0]        op_reg;
  logic [15:0]       dig_reg;
  logic [OPND_W-1:0] a_reg, b_reg;
  logic              err_pend_reg, neg_pend_reg;
  logic [CNT_W-1:0]  iter_cnt_reg;
  logic [RES_W-1:0]  acc_reg, mcand_reg;
  logic [OPND_W-1:0] mplier_reg, rem_reg, quo_reg;
  logic [15:0]       res_reg;
  logic              res_neg_reg, err_reg;

  // LOAD-cycle operand conversion and error detection
  logic [OPND_W-1:0] a_load, b_load;
  logic              op_valid, digits_bad, err_load;

  assign a_load     = bcd2bin(dig_reg[15:12], dig_reg[11:8]);
  assign b_load     = bcd2bin(dig_reg[7:4], dig_reg[3:0]);
  assign op_valid   = (op_reg == OP_ADD) || (op_reg == OP_SUB) ||
                      (op_reg == OP_MUL) || (op_reg == OP_DIV);
  assign digits_bad = digit_bad(dig_reg[15:12]) || digit_bad(dig_reg[11:8]) ||
                      digit_bad(dig_reg[7:4])   || digit_bad(dig_reg[3:0]);
  assign err_load   = !op_valid || digits_bad || ((op_reg == OP_DIV) && (b_load == '0));

  // EXEC arithmetic
  logic [RES_W-1:0]  add_r, sub_r, acc_next, exec_r, conv_bin;
  logic              a_ge_b;
  logic [OPND_W:0]   div_shift;
  logic [OPND_W+1:0] div_trial;
  logic              div_ok;
  logic [OPND_W-1:0] rem_next, quo_next;

  assign add_r     = RES_W'(a_reg) + RES_W'(b_reg);
  assign a_ge_b    = a_reg >= b_reg;
  assign sub_r     = a_ge_b ? RES_W'(a_reg - b_reg) : RES_W'(b_reg - a_reg);
  assign acc_next  = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;

  // Restoring division: bring down the next dividend bit, keep the trial if it did not borrow
  assign div_shift = {rem_reg, quo_reg[OPND_W-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, b_reg};
  assign div_ok    = ~div_trial[OPND_W+1];
  assign rem_next  = div_ok ? div_trial[OPND_W-1:0] : div_shift[OPND_W-1:0];
  assign quo_next  = {quo_reg[OPND_W-2:0], div_ok};

  // Mul/div results include the final iteration so the converter loads on the EXEC exit edge
  always_comb begin
    exec_r = '0;
    case (op_reg)
      OP_ADD:  exec_r = add_r;
      OP_SUB:  exec_r = sub_r;
      OP_MUL:  exec_r = acc_next;
      OP_DIV:  exec_r = RES_W'(quo_next);
      default: exec_r = '0;
    endcase
  end

  assign conv_bin = err_pend_reg ? '0 : exec_r;

  logic        exec_last, conv_load, conv_busy, conv_done, conv_finish;
  logic [15:0] conv_bcd;

  assign exec_last   = (state_reg == ST_EXEC) && (iter_cnt_reg == '0);
  assign conv_load   = exec_last && !abort;
  assign conv_finish = (state_reg == ST_CONV) && (iter_cnt_reg == '0) && conv_done && !conv_busy;

  bin2bcd_seq #(
    .BIN_W  (RES_W),
    .DIGITS (4)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .load (conv_load),
    .bin  (conv_bin),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_EXEC;
      ST_EXEC: if (iter_cnt_reg == '0) state_next = ST_CONV;
      ST_CONV: if (conv_finish) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_comb begin
    busy = (state_reg != ST_IDLE);
    done = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg       <= '0;
      dig_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      err_pend_reg <= 1'b0;
      neg_pend_reg <= 1'b0;
      iter_cnt_reg <= '0;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      res_reg      <= '0;
      res_neg_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else if (abort) begin
      err_pend_reg <= 1'b0;
      neg_pend_reg <= 1'b0;
      iter_cnt_reg <= '0;
      acc_reg      <= '0;
      res_reg      <= '0;
      res_neg_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg  <= op;
            dig_reg <= {a_tens, a_ones, b_tens, b_ones};
          end
        end
        ST_LOAD: begin
          a_reg        <= a_load;
          b_reg        <= b_load;
          err_pend_reg <= err_load;
          neg_pend_reg <= 1'b0;
          acc_reg      <= '0;
          mcand_reg    <= RES_W'(a_load);
          mplier_reg   <= b_load;
          rem_reg      <= '0;
          quo_reg      <= a_load;
          iter_cnt_reg <= ((op_reg == OP_MUL) || (op_reg == OP_DIV)) ? MULDIV_LAST : '0;
        end
        ST_EXEC: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          rem_reg    <= rem_next;
          quo_reg    <= quo_next;
          if (iter_cnt_reg == '0) begin
            iter_cnt_reg <= CONV_LAST;
            neg_pend_reg <= (op_reg == OP_SUB) && !a_ge_b && !err_pend_reg;
          end else begin
            iter_cnt_reg <= iter_cnt_reg - 1'b1;
          end
        end
        ST_CONV: begin
          if (iter_cnt_reg != '0) begin
            iter_cnt_reg <= iter_cnt_reg - 1'b1;
          end else if (conv_finish) begin
            res_reg     <= conv_bcd;
            res_neg_reg <= neg_pend_reg;
            err_reg     <= err_pend_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_d3  = res_reg[15:12];
  assign res_d2  = res_reg[11:8];
  assign res_d1  = res_reg[7:4];
  assign res_d0  = res_reg[3:0];
  assign res_neg = res_neg_reg;
  assign err     = err_reg;

endmodule
